fetch_decode_stage: RTL and testbench
=====================================

# fetch_decode_stage

Fetch-stage controller for the Y86-64 processor, downstream of the instruction memory. It owns the PC register, drives it to the instruction memory, and splits the returned 10 instruction bytes into icode/ifun/rA/rB/valC. It also computes valP and the predicted next PC. Decoded instructions go to the decode stage through a valid/ready output register; redirects from later stages, `ret` stalls, halt and error status are handled here.

## Interface
- `RESET_PC`, 64'd0, PC loaded on reset.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `PC` out 64: fetch address to instruction memory.
- `byte0` in 8: byte at PC (icode[7:4], ifun[3:0]).
- `byte19` in 72: bytes PC+1..PC+9; [71:64]=PC+1, [63:56]=PC+2, …, [7:0]=PC+9.
- `imem_err` in 1: instruction-memory address error, aligned with bytes.
- `redirect_valid` in 1: later stage supplies corrected PC (mispredict, ret target).
- `redirect_pc` in 64: corrected PC.
- `out_ready` in 1: decode stage accepts output this cycle.
- `out_valid` out 1: output register holds an instruction.
- `icode`, `ifun` out 4 each; `rA`, `rB` out 4 each (4'hF when unused); `valC` out 64; `valP` out 64.
- `stat` out 3: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `halted` out 1: fetch stopped permanently until reset.

## Operation
- States: FETCH, DECODE, WAIT_RET, HALT.
- FETCH: PC stable; the memory samples it at the next edge; go to DECODE.
- DECODE: bytes valid. Instruction length by icode: 0,1,9 → 1; 2,6,A,B → 2; 7,8 → 9; 3,4,5 → 10.
- need_regids for 2,3,4,5,6,A,B: rA=byte19[71:68], rB=byte19[67:64]; otherwise both 4'hF.
- need_valC for 3,4,5,7,8. valC is little-endian:
  - with regids: valC[7:0]=PC+2 … valC[63:56]=PC+9;
  - without regids: valC[7:0]=PC+1 … valC[63:56]=PC+8;
  - otherwise valC=0.
- valP = PC + length, 64-bit, wraps modulo 2^64.
- Valid ifun: icode 2 and 7 allow 0–6; icode 6 allows 0–3; all others require 0.
- stat priority: imem_err → ADR; icode > 4'hB or bad ifun → INS; icode 0 → HLT; else AOK.
- Load condition: DECODE and (!out_valid or out_ready). On load, all fields are written to the output register and out_valid is set to 1.
- Next PC after load:
  - stat ≠ AOK → HALT; PC held.
  - icode 7 or 8 → PC=valC (predict taken); go to FETCH.
  - icode 9 → WAIT_RET; PC held.
  - else → PC=valP; go to FETCH.
- If the load condition is false, remain in DECODE with PC held. Memory re-reads the same address, so the bytes stay valid.
- WAIT_RET: no fetch; leave only by redirect.
- HALT: halted=1; ignore redirect; leave only by rst.
- Output register: out_valid clears when out_ready && out_valid && no new load that cycle. A simultaneous drain and load keeps out_valid=1 with the new fields.
- Redirect (any state except HALT) has highest priority:
  - PC ← redirect_pc; state ← FETCH;
  - out_valid ← 0; a pending DECODE is discarded.
  - If out_ready was high in the same cycle, the consumer has already taken the old entry.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, out_valid=0, icode=ifun=0, rA=rB=4'hF, valC=valP=0, stat=AOK, halted=0.
- Latency: PC driven in cycle n; bytes valid in cycle n+1 (DECODE); out_valid=1 and new PC visible from cycle n+2.
- Peak throughput is one instruction per 2 cycles.
- halted rises in the same cycle as out_valid of the faulting or halt instruction.
- rst asserted mid-operation takes effect at the next edge regardless of state, handshake or redirect.
- Redirect in DECODE on the same edge as a load: redirect wins; no load.

## Test plan
- Fetch irmovq at 0: bytes 30 FB 05 00×7 → cycle 2: out_valid=1, icode=3, ifun=0, rA=F, rB=B, valC=5, valP=10, PC=10.
- Program irmovq@0, irmovq@10 (30 FA 0A…), OPq@20 (60 BA), halt@22:
  - third instruction: icode=6, rA=B, rB=A, valP=22;
  - fourth: stat=HLT, halted=1, PC stays 22.
- Backpressure: hold out_ready=0 with out_valid=1 → fields and PC frozen, state DECODE. Release → next instruction loads on the same edge the old one drains.
- jXX: 70 40 00×7 at PC 0 → valC=0x40, valP=9, next PC=0x40. Redirect to 9 during the following DECODE → out_valid drops, next fetch from 9.
- ret (90) → WAIT_RET, no further out_valid. Redirect_pc=0x100 → fetch resumes at 0x100 two cycles later.
- Errors:
  - byte0=C0 → stat=INS, halted=1;
  - imem_err=1 → stat=ADR;
  - redirect after halt ignored; rst returns PC to RESET_PC.

Source files
------------

// File: rtl/fetch_decode_stage_if.sv
// Bundle of signals between the Y86-64 fetch/decode stage and its neighbours.
// The bundle covers the instruction-memory port, the redirect input from later
// stages, and the valid/ready output register toward the decode stage.
//   master : the fetch_decode_stage itself (drives PC and decoded fields)
//   slave  : the environment (memory, redirect source, decode consumer)
interface fetch_decode_stage_if;
  logic [63:0] PC;
  logic [7:0]  byte0;
  logic [71:0] byte19;
  logic        imem_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [2:0]  stat;
  logic        halted;

  modport master (
    output PC, out_valid, icode, ifun, rA, rB, valC, valP, stat, halted,
    input  byte0, byte19, imem_err, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  PC, out_valid, icode, ifun, rA, rB, valC, valP, stat, halted,
    output byte0, byte19, imem_err, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// Y86-64 fetch-stage controller.
// Owns the PC, splits the 10 instruction bytes returned by instruction memory
// into icode/ifun/rA/rB/valC, computes valP and the predicted next PC, and
// presents each decoded instruction through a valid/ready output register.
// Ports:
//   clk  - single clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - fetch_decode_stage_if.master: PC, byte0, byte19, imem_err,
//          redirect_valid/redirect_pc, out_ready/out_valid, icode, ifun,
//          rA, rB, valC, valP, stat, halted
module fetch_decode_stage #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input logic                   clk,
  input logic                   rst,
  fetch_decode_stage_if.master  bus
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_DECODE   = 2'd1,
    ST_WAIT_RET = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  // Instruction length in bytes; undefined icodes count as one byte.
  function automatic logic [3:0] insn_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: insn_len = 4'd2;
      4'h7, 4'h8:             insn_len = 4'd9;
      4'h3, 4'h4, 4'h5:       insn_len = 4'd10;
      default:                insn_len = 4'd1;
    endcase
  endfunction

  function automatic logic need_regids(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
      default:                                  need_regids = 1'b0;
    endcase
  endfunction

  function automatic logic need_valc(input logic [3:0] ic);
    case (ic)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = 1'b1;
      default:                      need_valc = 1'b0;
    endcase
  endfunction

  function automatic logic ifun_ok(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h2, 4'h7: ifun_ok = (fn <= 4'd6);
      4'h6:       ifun_ok = (fn <= 4'd3);
      default:    ifun_ok = (fn == 4'd0);
    endcase
  endfunction

  // Bytes arrive in address order (lowest address in the top byte); valC is
  // little-endian, so the first byte in memory becomes the least significant.
  function automatic logic [63:0] bswap64(input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      bswap64[8*i +: 8] = v[63-8*i -: 8];
    end
  endfunction

  state_t      state_r, state_next_s;
  logic [63:0] pc_r, pc_next_s;
  logic        out_valid_r, halted_r;
  logic [3:0]  icode_r, ifun_r, ra_r, rb_r;
  logic [63:0] valc_r, valp_r;
  logic [2:0]  stat_r;

  logic [3:0]  icode_s, ifun_s, ra_s, rb_s;
  logic [63:0] valc_s, valp_s;
  logic [2:0]  stat_s;
  logic        load_s, redirect_s;

  assign icode_s    = bus.byte0[7:4];
  assign ifun_s     = bus.byte0[3:0];
  // HALT is sticky: only rst leaves it, so redirects are masked there.
  assign redirect_s = bus.redirect_valid && (state_r != ST_HALT);

  // Split the instruction bytes into fields and classify status.
  always_comb begin
    ra_s   = 4'hF;
    rb_s   = 4'hF;
    valc_s = 64'd0;
    stat_s = STAT_AOK;
    if (need_regids(icode_s)) begin
      ra_s = bus.byte19[71:68];
      rb_s = bus.byte19[67:64];
    end else begin
      ra_s = 4'hF;
      rb_s = 4'hF;
    end
    if (!need_valc(icode_s)) begin
      valc_s = 64'd0;
    end else if (need_regids(icode_s)) begin
      valc_s = bswap64(bus.byte19[63:0]);
    end else begin
      valc_s = bswap64(bus.byte19[71:8]);
    end
    if (bus.imem_err) begin
      stat_s = STAT_ADR;
    end else if ((icode_s > 4'hB) || !ifun_ok(icode_s, ifun_s)) begin
      stat_s = STAT_INS;
    end else if (icode_s == 4'h0) begin
      stat_s = STAT_HLT;
    end else begin
      stat_s = STAT_AOK;
    end
  end

  // valP wraps naturally at 64 bits.
  assign valp_s = pc_r + {60'd0, insn_len(icode_s)};

  // Next-state and next-PC selection; redirect overrides everything but HALT.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    load_s       = 1'b0;
    if (redirect_s) begin
      state_next_s = ST_FETCH;
      pc_next_s    = bus.redirect_pc;
    end else begin
      case (state_r)
        ST_FETCH: begin
          state_next_s = ST_DECODE;
        end
        ST_DECODE: begin
          if (!out_valid_r || bus.out_ready) begin
            load_s = 1'b1;
            if (stat_s != STAT_AOK) begin
              state_next_s = ST_HALT;
            end else if ((icode_s == 4'h7) || (icode_s == 4'h8)) begin
              state_next_s = ST_FETCH;
              pc_next_s    = valc_s;
            end else if (icode_s == 4'h9) begin
              state_next_s = ST_WAIT_RET;
            end else begin
              state_next_s = ST_FETCH;
              pc_next_s    = valp_s;
            end
          end else begin
            // Consumer stalled: memory keeps re-reading the same PC.
            state_next_s = ST_DECODE;
          end
        end
        ST_WAIT_RET: state_next_s = ST_WAIT_RET;
        ST_HALT:     state_next_s = ST_HALT;
        default:     state_next_s = ST_FETCH;
      endcase
    end
  end

  // State, PC and halted flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_FETCH;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      pc_r     <= pc_next_s;
      halted_r <= (state_next_s == ST_HALT);
    end
  end

  // Output register toward decode: flush on redirect, load, or drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      icode_r     <= 4'h0;
      ifun_r      <= 4'h0;
      ra_r        <= 4'hF;
      rb_r        <= 4'hF;
      valc_r      <= 64'd0;
      valp_r      <= 64'd0;
      stat_r      <= STAT_AOK;
    end else if (redirect_s) begin
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      icode_r     <= icode_s;
      ifun_r      <= ifun_s;
      ra_r        <= ra_s;
      rb_r        <= rb_s;
      valc_r      <= valc_s;
      valp_r      <= valp_s;
      stat_r      <= stat_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.PC        = pc_r;
  assign bus.out_valid = out_valid_r;
  assign bus.icode     = icode_r;
  assign bus.ifun      = ifun_r;
  assign bus.rA        = ra_r;
  assign bus.rB        = rb_r;
  assign bus.valC      = valc_r;
  assign bus.valP      = valp_r;
  assign bus.stat      = stat_r;
  assign bus.halted    = halted_r;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage: a table of single-instruction
// vectors (reset, fetch from address 0, check the decoded output), followed
// by hand-written multi-cycle sequences for program flow, backpressure,
// redirect, ret and halt behaviour.
module tb_fetch_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_stage_if bus ();

  fetch_decode_stage #(.RESET_PC(64'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory model: combinational read at the current PC.
  logic [7:0] mem [0:1023];

  always_comb begin
    bus.byte0  = mem[bus.PC[9:0]];
    bus.byte19 = 72'd0;
    for (int i = 0; i < 9; i++) begin
      bus.byte19[71-8*i -: 8] = mem[10'(bus.PC + 64'(i + 1))];
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic load_bytes(input int addr, input logic [79:0] b);
    for (int i = 0; i < 10; i++) mem[(addr + i) % 1024] = b[79-8*i -: 8];
  endtask

  // Step until out_valid is seen, within a cycle budget.
  task automatic next_out(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      found = bus.out_valid;
    end
    chk({name, "_valid"}, 64'(found), 64'd1);
  endtask

  typedef struct {
    logic [79:0] bytes;
    logic        err;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        chk_valp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{80'h30FB0500000000000000, 1'b0, 4'h3, 4'h0, 4'hF, 4'hB, 64'h5, 64'd10, 64'd10, 3'd1, 1'b1};
    vecs[1]  = '{80'h70400000000000000000, 1'b0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'd9, 64'h40, 3'd1, 1'b1};
    vecs[2]  = '{80'h60BA0000000000000000, 1'b0, 4'h6, 4'h0, 4'hB, 4'hA, 64'h0, 64'd2, 64'd2, 3'd1, 1'b1};
    vecs[3]  = '{80'h10000000000000000000, 1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 64'd1, 3'd1, 1'b1};
    vecs[4]  = '{80'h00000000000000000000, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 64'd0, 3'd2, 1'b1};
    vecs[5]  = '{80'hC0000000000000000000, 1'b0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd0, 64'd0, 3'd4, 1'b0};
    vecs[6]  = '{80'h26340000000000000000, 1'b0, 4'h2, 4'h6, 4'h3, 4'h4, 64'h0, 64'd2, 64'd2, 3'd1, 1'b1};
    vecs[7]  = '{80'h27340000000000000000, 1'b0, 4'h2, 4'h7, 4'h3, 4'h4, 64'h0, 64'd2, 64'd0, 3'd4, 1'b1};
    vecs[8]  = '{80'h50128877665544332211, 1'b0, 4'h5, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 64'd10, 64'd10, 3'd1, 1'b1};
    vecs[9]  = '{80'h80080706050403020100, 1'b0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h0102030405060708, 64'd9, 64'h0102030405060708, 3'd1, 1'b1};
    vecs[10] = '{80'hA0F40000000000000000, 1'b0, 4'hA, 4'h0, 4'hF, 4'h4, 64'h0, 64'd2, 64'd2, 3'd1, 1'b1};
    vecs[11] = '{80'h90000000000000000000, 1'b0, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 64'd0, 3'd1, 1'b1};
    vecs[12] = '{80'h30FB0500000000000000, 1'b1, 4'h3, 4'h0, 4'hF, 4'hB, 64'h5, 64'd10, 64'd0, 3'd3, 1'b1};
    vecs[13] = '{80'h66120000000000000000, 1'b0, 4'h6, 4'h6, 4'h1, 4'h2, 64'h0, 64'd2, 64'd0, 3'd4, 1'b1};

    bus.imem_err       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'd0;
    bus.out_ready      = 1'b1;
    clear_mem();
    @(negedge clk);

    // Reset state.
    do_reset();
    chk("rst_pc",        bus.PC,        64'd0);
    chk("rst_out_valid", bus.out_valid, 64'd0);
    chk("rst_icode",     bus.icode,     64'd0);
    chk("rst_ifun",      bus.ifun,      64'd0);
    chk("rst_rA",        bus.rA,        64'hF);
    chk("rst_rB",        bus.rB,        64'hF);
    chk("rst_valC",      bus.valC,      64'd0);
    chk("rst_valP",      bus.valP,      64'd0);
    chk("rst_stat",      bus.stat,      64'd1);
    chk("rst_halted",    bus.halted,    64'd0);

    // Table: one instruction at address 0, output expected two cycles after reset.
    for (int v = 0; v < 14; v++) begin
      clear_mem();
      load_bytes(0, vecs[v].bytes);
      bus.imem_err = vecs[v].err;
      do_reset();
      chk($sformatf("v%0d_pre_valid", v), bus.out_valid, 64'd0);
      tick();
      tick();
      chk($sformatf("v%0d_valid", v), bus.out_valid, 64'd1);
      chk($sformatf("v%0d_icode", v), bus.icode, vecs[v].icode);
      chk($sformatf("v%0d_ifun", v),  bus.ifun,  vecs[v].ifun);
      chk($sformatf("v%0d_rA", v),    bus.rA,    vecs[v].ra);
      chk($sformatf("v%0d_rB", v),    bus.rB,    vecs[v].rb);
      chk($sformatf("v%0d_valC", v),  bus.valC,  vecs[v].valc);
      if (vecs[v].chk_valp) chk($sformatf("v%0d_valP", v), bus.valP, vecs[v].valp);
      chk($sformatf("v%0d_stat", v),  bus.stat,  vecs[v].stat);
      chk($sformatf("v%0d_halted", v), bus.halted, 64'(vecs[v].stat != 3'd1));
      chk($sformatf("v%0d_pc", v),    bus.PC,    vecs[v].pc);
      bus.imem_err = 1'b0;
    end

    // Program: irmovq, irmovq, OPq, halt; then redirect after halt and reset.
    clear_mem();
    load_bytes(0,  80'h30FB0500000000000000);
    load_bytes(10, 80'h30FA0A00000000000000);
    load_bytes(20, 80'h60BA0000000000000000);
    mem[22] = 8'h00;
    mem[23] = 8'h00;
    do_reset();
    next_out("p1");
    chk("p1_valC", bus.valC, 64'd5);
    next_out("p2");
    chk("p2_valC", bus.valC, 64'hA);
    chk("p2_rB",   bus.rB,   64'hA);
    next_out("p3");
    chk("p3_icode", bus.icode, 64'h6);
    chk("p3_rA",    bus.rA,    64'hB);
    chk("p3_rB",    bus.rB,    64'hA);
    chk("p3_valP",  bus.valP,  64'd22);
    next_out("p4");
    chk("p4_stat",   bus.stat,   64'd2);
    chk("p4_halted", bus.halted, 64'd1);
    chk("p4_pc",     bus.PC,     64'd22);
    repeat (3) tick();
    chk("halt_pc_hold", bus.PC, 64'd22);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    tick();
    bus.redirect_valid = 1'b0;
    chk("halt_redir_pc",     bus.PC,     64'd22);
    chk("halt_redir_halted", bus.halted, 64'd1);
    do_reset();
    chk("halt_rst_pc",     bus.PC,     64'd0);
    chk("halt_rst_halted", bus.halted, 64'd0);

    // Backpressure: hold, then drain and load on the same edge.
    clear_mem();
    load_bytes(0,  80'h30FB0500000000000000);
    load_bytes(10, 80'h30FA0A00000000000000);
    bus.out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk("bp_valid", bus.out_valid, 64'd1);
    repeat (4) tick();
    chk("bp_hold_valid", bus.out_valid, 64'd1);
    chk("bp_hold_valC",  bus.valC,      64'd5);
    chk("bp_hold_pc",    bus.PC,        64'd10);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", bus.out_valid, 64'd1);
    chk("bp_rel_valC",  bus.valC,      64'hA);
    chk("bp_rel_pc",    bus.PC,        64'd20);

    // jXX predicted taken, then redirect wins over the pending DECODE load.
    clear_mem();
    load_bytes(0,    80'h70400000000000000000);
    load_bytes(9,    80'h30F30700000000000000);
    load_bytes(64,   80'h10000000000000000000);
    do_reset();
    tick();
    tick();
    chk("j_valC", bus.valC, 64'h40);
    chk("j_valP", bus.valP, 64'd9);
    chk("j_pc",   bus.PC,   64'h40);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'd9;
    tick();
    bus.redirect_valid = 1'b0;
    chk("j_redir_valid", bus.out_valid, 64'd0);
    chk("j_redir_pc",    bus.PC,        64'd9);
    next_out("j_tgt");
    chk("j_tgt_icode", bus.icode, 64'h3);
    chk("j_tgt_rB",    bus.rB,    64'h3);
    chk("j_tgt_valC",  bus.valC,  64'd7);
    chk("j_tgt_pc",    bus.PC,    64'd19);

    // ret: wait for redirect, then resume two cycles after it.
    clear_mem();
    mem[0] = 8'h90;
    load_bytes(256, 80'h20120000000000000000);
    do_reset();
    tick();
    tick();
    chk("ret_icode", bus.icode, 64'h9);
    begin
      logic any_valid;
      any_valid = 1'b0;
      repeat (5) begin
        tick();
        any_valid = any_valid | bus.out_valid;
      end
      chk("ret_no_valid", 64'(any_valid), 64'd0);
    end
    chk("ret_pc_hold", bus.PC, 64'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    tick();
    bus.redirect_valid = 1'b0;
    chk("ret_redir_pc", bus.PC, 64'h100);
    tick();
    tick();
    chk("ret_res_valid", bus.out_valid, 64'd1);
    chk("ret_res_icode", bus.icode,     64'h2);
    chk("ret_res_valP",  bus.valP,      64'h102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
